// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared types, default widths and helpers for the mips_cpu bus slice
//   arb_state_t : arbiter FSM states (IDLE, GNT_I, GNT_D)
//   requester_t : bus requesters (REQ_I = fetch, REQ_D = load/store)
//   gnt_of()    : grant state that serves a given requester
package mips_cpu_pkg;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;
    typedef enum logic {REQ_I, REQ_D} requester_t;

    function automatic arb_state_t gnt_of(requester_t r);
        return r == REQ_D ? GNT_D : GNT_I;
    endfunction
endpackage

// File: rtl/mips_cpu_bus_stall_timer.sv
// mips_cpu_bus_stall_timer: saturating stall counter with sticky timeout flag
//   clk, reset (async, active-low)
//   clear         : zero the counter (takes priority over inc)
//   inc           : count one stall cycle, saturating at TIMEOUT
//   stall_timeout : sticky, set on the edge the count reaches TIMEOUT
module mips_cpu_bus_stall_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic stall_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt           <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (inc && cnt != CW'(TIMEOUT))
                cnt <= cnt + 1'b1;
            if (!clear && inc && cnt == CW'(TIMEOUT - 1))
                stall_timeout <= 1'b1;
        end
endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: round-robin share of one Avalon-MM master between fetch (I) and data (D)
//   clk, reset (async, active-low)
//   i_*        : fetch requester (address, read, waitrequest out)
//   d_*        : data requester (address, read, write, writedata, byteenable, waitrequest out)
//   readdata_o : bus readdata broadcast to both requesters
//   address/read/write/writedata/byteenable/waitrequest/readdata : Avalon master port
//   grant_d    : D owns the bus this cycle
//   stall_timeout, proto_err : sticky error flags
module mips_cpu_bus_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   readdata_o,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,
    output logic                grant_d,
    output logic                stall_timeout,
    output logic                proto_err
);
    arb_state_t state, state_next;
    logic       last_d, last_d_next;
    logic       d_pend, gnt_req, other_pend, done, dropped;

    always_comb begin
        d_pend      = d_read | d_write;
        gnt_req     = state == GNT_I ? i_read : state == GNT_D ? d_pend : 1'b0;
        other_pend  = state == GNT_I ? d_pend : i_read;
        done        = gnt_req & ~waitrequest;
        dropped     = state != IDLE & ~gnt_req & waitrequest;
        state_next  = state;
        last_d_next = last_d;
        if (state == IDLE) begin
            // D wins unless both pend and D was served last
            if (i_read | d_pend)
                state_next = gnt_of((d_pend & ~(i_read & last_d)) ? REQ_D : REQ_I);
        end else if (!gnt_req) begin
            state_next = IDLE;
        end else if (done) begin
            last_d_next = state == GNT_D;
            state_next  = other_pend ? (state == GNT_D ? GNT_I : GNT_D) : IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_next;
            last_d    <= last_d_next;
            proto_err <= proto_err | (d_read & d_write) | dropped;
        end

    always_comb begin
        grant_d       = state == GNT_D;
        read          = state == GNT_I ? i_read : grant_d & d_read;
        write         = grant_d & d_write;
        address       = state == GNT_I ? i_address : grant_d ? d_address : '0;
        writedata     = grant_d ? d_writedata : '0;
        // fetches are full-word reads
        byteenable    = state == GNT_I ? '1 : grant_d ? d_byteenable : '0;
        i_waitrequest = state == GNT_I ? waitrequest : 1'b1;
        d_waitrequest = grant_d ? waitrequest : 1'b1;
        readdata_o    = readdata;
    end

    mips_cpu_bus_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
        .clk           (clk),
        .reset         (reset),
        .clear         (state_next != state),
        .inc           (state != IDLE & waitrequest),
        .stall_timeout (stall_timeout)
    );
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb_mips_cpu_bus_arbiter: directed bench with a per-cycle ownership model plus literal checks
module tb_mips_cpu_bus_arbiter;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_address = '0, d_address = '0, d_writedata = '0, readdata = '0;
    logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, waitrequest = 1'b1;
    logic [3:0]  d_byteenable = '0;
    logic        i_waitrequest, d_waitrequest, read, write, grant_d, stall_timeout, proto_err;
    logic [31:0] readdata_o, address, writedata;
    logic [3:0]  byteenable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest),
        .readdata_o(readdata_o), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .grant_d(grant_d), .stall_timeout(stall_timeout), .proto_err(proto_err)
    );

    // owner: 0 = nobody, 1 = fetch, 2 = data
    typedef struct packed {
        logic [1:0]  owner;
        logic        last_d;
        logic [15:0] stalls;
        logic        to;
        logic        perr;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t step(mstate_t s);
        mstate_t n = s;
        logic ir = i_read;
        logic dr = d_read | d_write;
        logic req;
        if (d_read && d_write) n.perr = 1'b1;
        if (s.owner == 2'd0) begin
            n.stalls = '0;
            if (ir && dr) n.owner = s.last_d ? 2'd1 : 2'd2;
            else if (dr) n.owner = 2'd2;
            else if (ir) n.owner = 2'd1;
        end else begin
            req = s.owner == 2'd1 ? ir : dr;
            if (!req || !waitrequest) begin
                if (!req && waitrequest) n.perr = 1'b1;
                if (req) n.last_d = s.owner == 2'd2;
                n.owner = (req && (s.owner == 2'd1 ? dr : ir)) ? 2'(3 - s.owner) : 2'd0;
                n.stalls = '0;
            end else begin
                n.stalls = s.stalls + 16'd1;
                if (n.stalls >= 16'(TIMEOUT)) n.to = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset)
        if (!reset) m <= '0;
        else m <= step(m);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("read", 64'(read), 64'(m.owner == 2'd1 ? i_read : m.owner == 2'd2 && d_read));
        chk("write", 64'(write), 64'(m.owner == 2'd2 && d_write));
        chk("address", 64'(address), 64'(m.owner == 2'd1 ? i_address : m.owner == 2'd2 ? d_address : 32'd0));
        chk("writedata", 64'(writedata), 64'(m.owner == 2'd2 ? d_writedata : 32'd0));
        chk("byteenable", 64'(byteenable), 64'(m.owner == 2'd1 ? 4'hF : m.owner == 2'd2 ? d_byteenable : 4'h0));
        chk("i_waitrequest", 64'(i_waitrequest), 64'(m.owner == 2'd1 ? waitrequest : 1'b1));
        chk("d_waitrequest", 64'(d_waitrequest), 64'(m.owner == 2'd2 ? waitrequest : 1'b1));
        chk("readdata_o", 64'(readdata_o), 64'(readdata));
        chk("grant_d", 64'(grant_d), 64'(m.owner == 2'd2));
        chk("stall_timeout", 64'(stall_timeout), 64'(m.to));
        chk("proto_err", 64'(proto_err), 64'(m.perr));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(3);
        reset = 1'b1;
        #1 chk("lit_rst_read", 64'(read), 64'd0);
        chk("lit_rst_iwait", 64'(i_waitrequest), 64'd1);
        chk("lit_rst_grant", 64'(grant_d), 64'd0);

        // fetch alone, two stall cycles then completion on cycle 3
        cyc(1);
        i_read = 1'b1; i_address = 32'hBFC00000; waitrequest = 1'b1;
        cyc(1);
        chk("lit_t2_read", 64'(read), 64'd1);
        chk("lit_t2_addr", 64'(address), 64'hBFC00000);
        chk("lit_t2_iwait_c1", 64'(i_waitrequest), 64'd1);
        cyc(2);
        waitrequest = 1'b0; readdata = 32'h12345678;
        #1 chk("lit_t2_iwait_c3", 64'(i_waitrequest), 64'd0);
        chk("lit_t2_rdata", 64'(readdata_o), 64'h12345678);
        cyc(1);
        i_read = 1'b0; waitrequest = 1'b1;
        #1 chk("lit_t2_idle", 64'(read), 64'd0);

        // simultaneous requests after a fetch: D store first, then I without a bubble
        cyc(1);
        d_write = 1'b1; d_address = 32'h100; d_writedata = 32'hDEADBEEF; d_byteenable = 4'hF;
        i_read = 1'b1; i_address = 32'h200;
        cyc(1);
        chk("lit_t3_grant_d", 64'(grant_d), 64'd1);
        chk("lit_t3_wdata", 64'(writedata), 64'hDEADBEEF);
        chk("lit_t3_iwait", 64'(i_waitrequest), 64'd1);
        cyc(1);
        waitrequest = 1'b0;
        #1 chk("lit_t3_dwait", 64'(d_waitrequest), 64'd0);
        chk("lit_t3_iwait2", 64'(i_waitrequest), 64'd1);
        cyc(1);
        d_write = 1'b0;
        #1 chk("lit_t3_gnt_i", 64'(grant_d), 64'd0);
        chk("lit_t3_iaddr", 64'(address), 64'h200);
        cyc(1);
        i_read = 1'b0; waitrequest = 1'b1;

        // both requesting continuously: grants alternate starting with D
        cyc(1);
        i_read = 1'b1; d_read = 1'b1; waitrequest = 1'b0; d_address = 32'h300;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk($sformatf("lit_t4_grant%0d", k), 64'(grant_d), 64'(k % 2 == 0));
        end
        d_read = 1'b0;
        cyc(1);
        i_read = 1'b0; waitrequest = 1'b1;

        // D load stalled for TIMEOUT cycles
        cyc(1);
        d_read = 1'b1;
        cyc(4);
        chk("lit_t5_to_c3", 64'(stall_timeout), 64'd0);
        cyc(1);
        chk("lit_t5_to_c4", 64'(stall_timeout), 64'd1);
        waitrequest = 1'b0;
        cyc(1);
        d_read = 1'b0; waitrequest = 1'b1;
        #1 chk("lit_t5_sticky", 64'(stall_timeout), 64'd1);

        // read and write together for one cycle
        cyc(1);
        d_read = 1'b1; d_write = 1'b1;
        #1 chk("lit_t6_perr0", 64'(proto_err), 64'd0);
        cyc(1);
        chk("lit_t6_perr1", 64'(proto_err), 64'd1);
        d_read = 1'b0; waitrequest = 1'b0;
        cyc(1);
        d_write = 1'b0; i_read = 1'b1; i_address = 32'h400;
        cyc(1);
        chk("lit_t6_iread", 64'(read), 64'd1);
        chk("lit_t6_iwait", 64'(i_waitrequest), 64'd0);
        cyc(1);
        i_read = 1'b0; waitrequest = 1'b1;
        #1 chk("lit_t6_sticky", 64'(proto_err), 64'd1);

        // reset in the middle of a stalled D write
        cyc(1);
        d_write = 1'b1; d_address = 32'h500; d_writedata = 32'hCAFEF00D;
        cyc(1);
        chk("lit_t1_write", 64'(write), 64'd1);
        #2 reset = 1'b0;
        #1 chk("lit_t1_write0", 64'(write), 64'd0);
        chk("lit_t1_dwait", 64'(d_waitrequest), 64'd1);
        chk("lit_t1_perr", 64'(proto_err), 64'd0);
        chk("lit_t1_to", 64'(stall_timeout), 64'd0);
        cyc(1);
        d_write = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        chk("lit_t1_idle_grant", 64'(grant_d), 64'd0);
        chk("lit_t1_idle_write", 64'(write), 64'd0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
